// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package fetch_unit_pkg;

    localparam int          INSTR_W          = 32;
    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Width of counters that must hold 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO: registered storage, combinational head read, flush empties it in one edge.
module fetch_unit_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            data_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    output logic [WIDTH-1:0]            data_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [cnt_width(DEPTH)-1:0] count_o
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated only with non-blocking assignments.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the empty flag guards every read of it.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (count_o == cnt_width(DEPTH)'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order imem reads, prefetch FIFO, redirect flush.
// Optional FETCH_PERF_EN adds saturating flush/stall event counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid_o,
    input  logic               imem_req_ready_i,
    output logic [ADDR_W-1:0]  imem_req_addr_o,
    input  logic               imem_rsp_valid_i,
    input  logic [INSTR_W-1:0] imem_rsp_data_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_flush_o,
    output logic [15:0]        perf_stall_o
`endif
);

    localparam int                CNT_W   = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(WORD_BYTES);

    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic [ADDR_W-1:0]         rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]          outst_q, outst_d;
    logic [CNT_W-1:0]          drop_q, drop_d;
    logic [CNT_W-1:0]          fifo_count;
    logic [CNT_W:0]            in_use;
    logic                      run_q;
    logic                      req_hs, rsp_keep, fifo_push, pop;
    logic                      fifo_empty, fifo_full;
    logic [ADDR_W+INSTR_W-1:0] fifo_head;
    logic [ADDR_W-1:0]         redirect_target;

    // Requests are held off for the first cycle out of reset so none leak while reset is low.
    assign in_use           = {1'b0, outst_q} + {1'b0, fifo_count};
    assign imem_req_valid_o = run_q && !redirect_i && (in_use < (CNT_W+1)'(DEPTH));
    assign imem_req_addr_o  = pc_q;
    assign req_hs           = imem_req_valid_o && imem_req_ready_i;
    assign redirect_target  = {redirect_pc_i[ADDR_W-1:2], 2'b00};

    assign rsp_keep  = imem_rsp_valid_i && (drop_q == '0) && !redirect_i;
    assign fifo_push = rsp_keep && (!fifo_full || pop);
    assign pop       = instr_valid_o && instr_ready_i && !redirect_i;

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        if (redirect_i) begin
            // A response in this cycle belongs to an already-counted request, so it retires one.
            pc_d     = redirect_target;
            rsp_pc_d = redirect_target;
            outst_d  = '0;
            drop_d   = drop_q + outst_q - (imem_rsp_valid_i ? CNT_ONE : '0);
        end else begin
            if (req_hs) pc_d = pc_q + PC_STEP;
            if (imem_rsp_valid_i) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_ONE;
                end else begin
                    outst_d  = outst_q - CNT_ONE;
                    rsp_pc_d = rsp_pc_q + PC_STEP;
                end
            end
            if (req_hs) outst_d = outst_d + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
            run_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            run_q    <= 1'b1;
        end
    end

    fetch_unit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  ({rsp_pc_q, imem_rsp_data_i}),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? '0 : fifo_head[INSTR_W-1:0];
    assign instr_pc_o    = fifo_empty ? '0 : fifo_head[ADDR_W+INSTR_W-1:INSTR_W];

`ifdef FETCH_PERF_EN
    logic [15:0] perf_flush_q, perf_stall_q;

    // A stall is any running, non-redirect cycle in which no request was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_flush_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (redirect_i && perf_flush_q != 16'hFFFF)
                perf_flush_q <= perf_flush_q + 16'd1;
            if (run_q && !redirect_i && !req_hs && perf_stall_q != 16'hFFFF)
                perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign perf_flush_o = perf_flush_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with random latency and a stream-level reference.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_flush, perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_flush_o     (perf_flush),
        .perf_stall_o     (perf_stall)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Per-cycle stimulus, applied on the falling edge by cycle().
    logic        cfg_rst = 1'b0, cfg_ready = 1'b0, cfg_iready = 1'b0, cfg_redirect = 1'b0;
    logic [31:0] cfg_rpc = '0;
    int          min_lat = 1, max_lat = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t memq[$];
    int    last_due = -1;

    // Reference: the delivered stream is sequential words from the last redirect target.
    logic [31:0] exp_req_pc, exp_out_pc;
    int          issued, consumed, since_rst, hs_count, first_hs_cyc, first_valid_cyc;
    logic [31:0] consumed_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        exp_req_pc      = 32'h0;
        exp_out_pc      = 32'h0;
        issued          = 0;
        consumed        = 0;
        since_rst       = 0;
        hs_count        = 0;
        first_hs_cyc    = -1;
        first_valid_cyc = -1;
        consumed_q.delete();
    endtask

    task automatic monitor();
        int occ;
        int lat;
        int due;
        mreq_t m;
        occ = issued - consumed;
        if (since_rst > 0) begin
            n_checks++;
            if (req_valid !== (!redirect && occ < DEPTH)) begin
                n_fail++;
                $display("FAIL credit cyc=%0d: req_valid=%b want %b (occupancy %0d, redirect %b)",
                         cyc, req_valid, (!redirect && occ < DEPTH), occ, redirect);
            end
        end
        if (req_valid && req_ready) begin
            n_checks++;
            if (req_addr !== exp_req_pc) begin
                n_fail++;
                $display("FAIL req_addr cyc=%0d: got %h want %h", cyc, req_addr, exp_req_pc);
            end
            lat    = $urandom_range(max_lat, min_lat);
            due    = (last_due + 1 > cyc + lat) ? last_due + 1 : cyc + lat;
            last_due = due;
            m.addr = req_addr;
            m.due  = due;
            memq.push_back(m);
            exp_req_pc = exp_req_pc + 32'd4;
            issued++;
            hs_count++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
        end
        if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (instr_valid && instr_ready && !redirect) begin
            n_checks++;
            if (instr_pc !== exp_out_pc || instr !== mem_word(exp_out_pc)) begin
                n_fail++;
                $display("FAIL instr cyc=%0d: got pc %h data %h want pc %h data %h",
                         cyc, instr_pc, instr, exp_out_pc, mem_word(exp_out_pc));
            end
            consumed_q.push_back(instr_pc);
            exp_out_pc = exp_out_pc + 32'd4;
            consumed++;
        end
        if (redirect) begin
            exp_req_pc = redirect_pc & ~32'd3;
            exp_out_pc = redirect_pc & ~32'd3;
            issued     = 0;
            consumed   = 0;
            consumed_q.delete();
        end
        since_rst++;
    endtask

    task automatic cycle();
        @(negedge clk);
        rst_n       = cfg_rst;
        req_ready   = cfg_ready;
        instr_ready = cfg_iready;
        redirect    = cfg_redirect;
        redirect_pc = cfg_rpc;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        if (!cfg_rst) begin
            memq.delete();
            last_due = -1;
            model_reset();
        end else if (memq.size() > 0 && memq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end
        #1;
        if (rst_n) monitor();
        cyc++;
    endtask

    task automatic do_reset();
        cfg_rst = 1'b0; cfg_ready = 1'b0; cfg_iready = 1'b0; cfg_redirect = 1'b0;
        cycle();
        cycle();
        cfg_rst = 1'b1;
    endtask

    task automatic test_reset(input string tag);
        cfg_rst = 1'b0;
        cycle();
        n_checks++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL %s_req_valid: got %b want 0", tag, req_valid); end
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL %s_instr_valid: got %b want 0", tag, instr_valid); end
        n_checks++;
        if (req_addr !== 32'h0) begin n_fail++; $display("FAIL %s_req_addr: got %h want 0", tag, req_addr); end
        n_checks++;
        if (instr !== 32'h0 || instr_pc !== 32'h0) begin
            n_fail++; $display("FAIL %s_instr: got %h pc %h want 0 pc 0", tag, instr, instr_pc);
        end
        cycle();
        cfg_rst = 1'b1;
    endtask

    task automatic test_stream();
        do_reset();
        min_lat = 1; max_lat = 1;
        cfg_ready = 1'b1; cfg_iready = 1'b1;
        repeat (20) cycle();
        n_checks++;
        if (first_hs_cyc < 0 || first_valid_cyc - first_hs_cyc != 2) begin
            n_fail++;
            $display("FAIL stream_latency: got %0d cycles want 2", first_valid_cyc - first_hs_cyc);
        end
        n_checks++;
        if (consumed_q.size() < 15 || consumed_q[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL stream_words: got %0d words want >=15 starting at pc 0", consumed_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] want;
        do_reset();
        min_lat = 1; max_lat = 1;
        cfg_ready = 1'b1; cfg_iready = 1'b0;
        repeat (20) cycle();
        n_checks++;
        if (hs_count != DEPTH) begin n_fail++; $display("FAIL bp_requests: got %0d want %0d", hs_count, DEPTH); end
        n_checks++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b want 0", req_valid); end
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_head: got valid %b pc %h want 1 pc 0", instr_valid, instr_pc);
        end
        cfg_iready = 1'b1;
        repeat (4) cycle();
        for (int i = 0; i < 4; i++) begin
            want = 32'(i * 4);
            n_checks++;
            if (consumed_q.size() <= i || consumed_q[i] !== want) begin
                n_fail++; $display("FAIL bp_drain_%0d: want pc %h, got %0d words", i, want, consumed_q.size());
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        min_lat = 3; max_lat = 3;
        cfg_ready = 1'b1; cfg_iready = 1'b1;
        repeat (3) cycle();
        cfg_redirect = 1'b1; cfg_rpc = 32'h0000_0105;
        cycle();
        n_checks++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_req_blocked: got %b want 0", req_valid); end
        cfg_redirect = 1'b0;
        cycle();
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h0000_0104) begin
            n_fail++; $display("FAIL redir_addr: got valid %b addr %h want 1 addr 104", req_valid, req_addr);
        end
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got valid %b want 0", instr_valid); end
        repeat (10) cycle();
        n_checks++;
        if (consumed_q.size() == 0 || consumed_q[0] !== 32'h0000_0104) begin
            n_fail++; $display("FAIL redir_first_pc: got %0d words want first pc 104", consumed_q.size());
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
`ifdef FETCH_PERF_EN
        logic [15:0] stall_before;
`endif
        do_reset();
        min_lat = 1; max_lat = 1;
        cfg_ready = 1'b1; cfg_iready = 1'b1;
        repeat (5) cycle();
`ifdef FETCH_PERF_EN
        stall_before = perf_stall;
`endif
        cfg_ready = 1'b0;
        held = exp_req_pc;
        repeat (5) begin
            cycle();
            n_checks++;
            if (req_valid !== 1'b1 || req_addr !== held) begin
                n_fail++; $display("FAIL stall_hold: got valid %b addr %h want 1 addr %h", req_valid, req_addr, held);
            end
        end
        cfg_ready = 1'b1;
        cycle();
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_stall - stall_before != 16'd5) begin
            n_fail++; $display("FAIL perf_stall: got +%0d want +5", perf_stall - stall_before);
        end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        min_lat = 2; max_lat = 2;
        cfg_ready = 1'b1; cfg_iready = 1'b1;
        repeat (8) cycle();
        cfg_redirect = 1'b1; cfg_rpc = 32'h0000_2000;
        cycle();
        n_checks++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_req_blocked: got %b want 0", req_valid); end
        cfg_rpc = 32'h0000_300A;
        cycle();
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp_dropped: got valid %b want 0", instr_valid); end
        cfg_redirect = 1'b0;
        cycle();
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h0000_3008 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_last_wins: got valid %b addr %h ivalid %b want 1 3008 0",
                               req_valid, req_addr, instr_valid);
        end
        repeat (12) cycle();
        n_checks++;
        if (consumed_q.size() == 0 || consumed_q[0] !== 32'h0000_3008) begin
            n_fail++; $display("FAIL b2b_first_pc: got %0d words want first pc 3008", consumed_q.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        min_lat = 1; max_lat = 1;
        cfg_ready = 1'b1; cfg_iready = 1'b1;
        cfg_redirect = 1'b1; cfg_rpc = 32'hFFFF_FFFE;
        cycle();
        cfg_redirect = 1'b0;
        cycle();
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_top: got valid %b addr %h want 1 fffffffc", req_valid, req_addr);
        end
        cycle();
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_zero: got valid %b addr %h want 1 0", req_valid, req_addr);
        end
        repeat (6) cycle();
        n_checks++;
        if (consumed_q.size() < 2 || consumed_q[0] !== 32'hFFFF_FFFC || consumed_q[1] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_stream: got %0d words want fffffffc then 0", consumed_q.size());
        end
        test_reset("midburst");
    endtask

    task automatic test_random();
        int total;
        do_reset();
        min_lat = 1; max_lat = 4;
        total = 0;
        for (int i = 0; i < 600; i++) begin
            cfg_ready    = ($urandom_range(3, 0) != 0);
            cfg_iready   = ($urandom_range(2, 0) != 0);
            cfg_redirect = ($urandom_range(19, 0) == 0) && (memq.size() <= 2 * DEPTH - 1);
            cfg_rpc      = $urandom;
            cycle();
            if (instr_valid && instr_ready && !redirect) total++;
        end
        cfg_redirect = 1'b0;
        n_checks++;
        if (total < 100) begin n_fail++; $display("FAIL random_throughput: got %0d words want >=100", total); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset("init");
        test_stream();
        test_backpressure();
        test_redirect();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
